// File: rtl/dma_transfer_sequencer_pkg.sv
// rtl/dma_transfer_sequencer_pkg.sv - shared types and helpers for the DMA transfer sequencer
package dma_pkg;

    localparam int NCH = 4;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DEMAND = 2'b00,
        SINGLE = 2'b01,
        BLOCK  = 2'b10
    } xfer_mode_t;

    typedef enum logic [1:0] {
        VERIFY = 2'b00,
        WRITE  = 2'b01,
        READ   = 2'b10
    } xfer_type_t;

    // Index of the set bit in a one-hot grant; highest set bit wins if the arbiter misbehaves.
    function automatic logic [1:0] chanIdx(input logic [NCH-1:0] oneHot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NCH; i++) begin
            if (oneHot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_transfer_sequencer_if.sv
// rtl/dma_transfer_sequencer_if.sv - register-file and system-bus signals of the DMA sequencer
interface dma_transfer_sequencer_if;
    import dma_pkg::*;

    logic [NCH-1:0]      DREQ;
    logic                HLDA;
    logic                EOP_N_IN;
    logic [NCH-1:0]      maskReg;
    logic                ctrlEnable;
    logic [NCH-1:0][1:0] modeXfer;
    logic [NCH-1:0][1:0] modeType;
    logic [NCH-1:0]      grant;
    logic                countZero;
    logic                clearStatus;

    logic                HRQ;
    logic                assertDACK;
    logic [NCH-1:0]      DACK;
    logic                AEN;
    logic                ADSTB;
    logic                MEMR_N;
    logic                MEMW_N;
    logic                IOR_N;
    logic                IOW_N;
    logic                EOP_N_OUT;
    logic [1:0]          activeChannel;
    logic                updateAddrCount;
    logic [NCH-1:0]      tcStatus;

    modport master (
        input  DREQ, HLDA, EOP_N_IN, maskReg, ctrlEnable, modeXfer, modeType,
               grant, countZero, clearStatus,
        output HRQ, assertDACK, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
               EOP_N_OUT, activeChannel, updateAddrCount, tcStatus
    );

    modport slave (
        output DREQ, HLDA, EOP_N_IN, maskReg, ctrlEnable, modeXfer, modeType,
               grant, countZero, clearStatus,
        input  HRQ, assertDACK, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
               EOP_N_OUT, activeChannel, updateAddrCount, tcStatus
    );

endinterface

// File: rtl/dma_transfer_sequencer_strobe_gen.sv
// rtl/dma_transfer_sequencer_strobe_gen.sv - registered memory/IO command strobes decoded from next state
module dma_strobe_gen
    import dma_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  state_t     nextState,
    input  xfer_type_t xferType,
    output logic       MEMR_N,
    output logic       MEMW_N,
    output logic       IOR_N,
    output logic       IOW_N
);

    logic readOn;
    logic writeOn;

    assign readOn  = (nextState == S2) || (nextState == S3) || (nextState == S4);
    assign writeOn = (nextState == S3) || (nextState == S4);

    // Read side opens in S2, write side in S3; both held through S4; VERIFY drives neither.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEMR_N <= 1'b1;
            MEMW_N <= 1'b1;
            IOR_N  <= 1'b1;
            IOW_N  <= 1'b1;
        end else begin
            MEMR_N <= ~(readOn  && (xferType == READ));
            IOR_N  <= ~(readOn  && (xferType == WRITE));
            IOW_N  <= ~(writeOn && (xferType == READ));
            MEMW_N <= ~(writeOn && (xferType == WRITE));
        end
    end

endmodule

// File: rtl/dma_transfer_sequencer.sv
// rtl/dma_transfer_sequencer.sv - four-channel DMA hold/arbitration/S1-S4 transfer sequencer
module dma_transfer_sequencer
    import dma_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    dma_transfer_sequencer_if.master bus
);

    state_t         state;
    state_t         nextState;
    logic           pending;
    logic           terminate;
    logic           tcHit;
    logic           eopSeen;
    logic           latchGrant;
    logic           tcSet;
    xfer_mode_t     actMode;
    xfer_type_t     actType;

    logic           hrqQ, hrqD;
    logic           aenQ, aenD;
    logic           adstbQ, adstbD;
    logic           updQ, updD;
    logic           eopOutQ, eopOutD;
    logic [NCH-1:0] dackQ, dackD;
    logic [NCH-1:0] tcStatusQ, tcStatusD;
    logic [NCH-1:0] tcBit;
    logic [1:0]     chanQ, chanD;
    logic           memrN, memwN, iorN, iowN;

    assign pending = (|(bus.DREQ & ~bus.maskReg)) & bus.ctrlEnable;
    assign actMode = xfer_mode_t'(bus.modeXfer[chanQ]);
    assign actType = xfer_type_t'(bus.modeType[chanQ]);

    // Terminal count was seen on entry to this S4; EOP_N_OUT low marks exactly that.
    assign tcHit = ~eopOutQ;

    // Service ends after S4 on single mode, terminal count, external EOP or demand request gone.
    assign terminate = (actMode == SINGLE) || tcHit || eopSeen || !bus.EOP_N_IN ||
                       ((actMode == DEMAND) && !bus.DREQ[chanQ]);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= SI;
        else          state <= nextState;
    end

    // Next-state: hold request, arbitration on HLDA, S1-S4 loop, abort whenever HLDA drops.
    always_comb begin
        nextState = state;
        unique case (state)
            SI: if (pending) nextState = S0;
            S0: begin
                if (!pending)      nextState = SI;
                else if (bus.HLDA) nextState = S1;
            end
            S1: nextState = bus.HLDA ? S2 : SI;
            S2: nextState = bus.HLDA ? S3 : SI;
            S3: nextState = bus.HLDA ? S4 : SI;
            S4: nextState = (!bus.HLDA || terminate) ? SI : S1;
            default: nextState = SI;
        endcase
    end

    // Output decode from next state so every registered output changes with the state itself.
    always_comb begin
        latchGrant = (state == S0) && (nextState == S1);
        hrqD       = (nextState != SI);
        aenD       = (nextState == S1) || (nextState == S2) || (nextState == S3) || (nextState == S4);
        adstbD     = (nextState == S1);
        updD       = (nextState == S4);
        tcSet      = (nextState == S4) && bus.countZero;
        eopOutD    = ~tcSet;
        dackD      = dackQ;
        chanD      = chanQ;
        if (latchGrant) begin
            dackD = bus.grant;
            chanD = chanIdx(bus.grant);
        end else if (nextState == SI) begin
            dackD = '0;
            chanD = 2'd0;
        end
        tcBit        = '0;
        tcBit[chanQ] = 1'b1;
        tcStatusD    = (bus.clearStatus ? '0 : tcStatusQ) | (tcSet ? tcBit : '0);
    end

    // Registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hrqQ      <= 1'b0;
            aenQ      <= 1'b0;
            adstbQ    <= 1'b0;
            updQ      <= 1'b0;
            eopOutQ   <= 1'b1;
            dackQ     <= '0;
            chanQ     <= 2'd0;
            tcStatusQ <= '0;
        end else begin
            hrqQ      <= hrqD;
            aenQ      <= aenD;
            adstbQ    <= adstbD;
            updQ      <= updD;
            eopOutQ   <= eopOutD;
            dackQ     <= dackD;
            chanQ     <= chanD;
            tcStatusQ <= tcStatusD;
        end
    end

    // External EOP is remembered from any S2-S4 edge until the transfer finishes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            eopSeen <= 1'b0;
        else if ((state == S2) || (state == S3) || (state == S4))
            eopSeen <= eopSeen | ~bus.EOP_N_IN;
        else
            eopSeen <= 1'b0;
    end

    dma_strobe_gen u_strobe (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .nextState (nextState),
        .xferType  (actType),
        .MEMR_N    (memrN),
        .MEMW_N    (memwN),
        .IOR_N     (iorN),
        .IOW_N     (iowN)
    );

    assign bus.assertDACK      = (state == S0) && bus.HLDA && pending;
    assign bus.HRQ             = hrqQ;
    assign bus.AEN             = aenQ;
    assign bus.ADSTB           = adstbQ;
    assign bus.updateAddrCount = updQ;
    assign bus.EOP_N_OUT       = eopOutQ;
    assign bus.DACK            = dackQ;
    assign bus.activeChannel   = chanQ;
    assign bus.tcStatus        = tcStatusQ;
    assign bus.MEMR_N          = memrN;
    assign bus.MEMW_N          = memwN;
    assign bus.IOR_N           = iorN;
    assign bus.IOW_N           = iowN;

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// tb/tb_dma_transfer_sequencer.sv - self-checking bench for the DMA transfer sequencer
module tb_dma_transfer_sequencer;
    import dma_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   checkEn = 1'b0;

    always #5 CLK = ~CLK;

    dma_transfer_sequencer_if bus();

    dma_transfer_sequencer dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 holding for HLDA, 2 transferring; pos = cycle 1..4 of a word.
    int         mPhase, mPos, mChan;
    bit         mEop, mTc;
    logic [3:0] mTcStatus;

    function automatic int gIdx(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit mPend();
        return ((bus.DREQ & ~bus.maskReg) != 4'b0) && bus.ctrlEnable;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mPhase = 0; mPos = 0; mChan = 0; mEop = 0; mTc = 0; mTcStatus = 4'b0;
        end else begin
            bit setTc;
            bit pend;
            setTc = 0;
            pend  = mPend();
            if (mPhase == 0) begin
                if (pend) mPhase = 1;
            end else if (mPhase == 1) begin
                if (!pend) mPhase = 0;
                else if (bus.HLDA) begin mPhase = 2; mPos = 1; mChan = gIdx(bus.grant); mEop = 0; mTc = 0; end
            end else begin
                if (!bus.HLDA) begin
                    mPhase = 0; mPos = 0;
                end else begin
                    if (mPos >= 2 && !bus.EOP_N_IN) mEop = 1;
                    if (mPos == 4) begin
                        if (bus.modeXfer[mChan] == SINGLE || mTc || mEop ||
                            (bus.modeXfer[mChan] == DEMAND && !bus.DREQ[mChan])) begin
                            mPhase = 0; mPos = 0;
                        end else begin
                            mPos = 1; mEop = 0; mTc = 0;
                        end
                    end else begin
                        mPos = mPos + 1;
                        if (mPos == 4) begin mTc = bus.countZero; setTc = bus.countZero; end
                    end
                end
            end
            if (!mPhase[1]) mPos = (mPhase == 2) ? mPos : 0;
            if (bus.clearStatus) mTcStatus = 4'b0;
            if (setTc) mTcStatus[mChan] = 1'b1;
        end
    end

    // Literal event counters for per-scenario hand-computed expectations.
    int nAssert, nUpd, nMemrLow, nIowLow, nIorLow, nMemwLow, nAen, nEopLow;

    task automatic clrCnt();
        nAssert = 0; nUpd = 0; nMemrLow = 0; nIowLow = 0; nIorLow = 0; nMemwLow = 0; nAen = 0; nEopLow = 0;
    endtask

    // Compare process: DUT against the model on every clock while out of reset.
    always @(negedge CLK) begin
        if (RESET_N && checkEn) begin
            bit xfer, rd, wr;
            logic [1:0] typ;
            xfer = (mPhase == 2);
            rd   = xfer && mPos >= 2;
            wr   = xfer && mPos >= 3;
            typ  = bus.modeType[mChan];
            chk("HRQ",        32'(bus.HRQ),        32'(mPhase != 0));
            chk("assertDACK", 32'(bus.assertDACK), 32'(mPhase == 1 && bus.HLDA && mPend()));
            chk("AEN",        32'(bus.AEN),        32'(xfer));
            chk("ADSTB",      32'(bus.ADSTB),      32'(xfer && mPos == 1));
            chk("DACK",       32'(bus.DACK),       xfer ? (32'd1 << mChan) : 32'd0);
            chk("activeChannel", 32'(bus.activeChannel), xfer ? 32'(mChan) : 32'd0);
            chk("updateAddrCount", 32'(bus.updateAddrCount), 32'(xfer && mPos == 4));
            chk("EOP_N_OUT",  32'(bus.EOP_N_OUT),  32'(!(xfer && mPos == 4 && mTc)));
            chk("tcStatus",   32'(bus.tcStatus),   32'(mTcStatus));
            chk("MEMR_N",     32'(bus.MEMR_N),     32'(!(rd && typ == READ)));
            chk("IOR_N",      32'(bus.IOR_N),      32'(!(rd && typ == WRITE)));
            chk("IOW_N",      32'(bus.IOW_N),      32'(!(wr && typ == READ)));
            chk("MEMW_N",     32'(bus.MEMW_N),     32'(!(wr && typ == WRITE)));
            nAssert  += int'(bus.assertDACK);
            nUpd     += int'(bus.updateAddrCount);
            nMemrLow += int'(!bus.MEMR_N);
            nIowLow  += int'(!bus.IOW_N);
            nIorLow  += int'(!bus.IOR_N);
            nMemwLow += int'(!bus.MEMW_N);
            nAen     += int'(bus.AEN);
            nEopLow  += int'(!bus.EOP_N_OUT);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge CLK); #3; end
    endtask

    initial begin
        bus.DREQ = 4'b0; bus.HLDA = 1'b0; bus.EOP_N_IN = 1'b1; bus.maskReg = 4'b0;
        bus.ctrlEnable = 1'b1; bus.modeXfer = '0; bus.modeType = '0; bus.grant = 4'b0;
        bus.countZero = 1'b0; bus.clearStatus = 1'b0;
        clrCnt();
        cyc(2);
        chk("rst_HRQ", 32'(bus.HRQ), 32'd0);
        chk("rst_MEMR_N", 32'(bus.MEMR_N), 32'd1);
        chk("rst_EOP_N_OUT", 32'(bus.EOP_N_OUT), 32'd1);
        chk("rst_tcStatus", 32'(bus.tcStatus), 32'd0);
        RESET_N = 1'b1;
        checkEn = 1'b1;
        cyc(2);

        // Ch2 SINGLE READ, HLDA two cycles after HRQ.
        clrCnt();
        bus.modeXfer[2] = SINGLE; bus.modeType[2] = READ; bus.grant = 4'b0100; bus.DREQ = 4'b0100;
        cyc(1);
        chk("A_HRQ_after_dreq", 32'(bus.HRQ), 32'd1);
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(1);
        chk("A_DACK", 32'(bus.DACK), 32'h4);
        chk("A_activeChannel", 32'(bus.activeChannel), 32'd2);
        bus.DREQ = 4'b0;
        cyc(5);
        bus.HLDA = 1'b0;
        chk("A_assert_pulses", 32'(nAssert), 32'd1);
        chk("A_updates", 32'(nUpd), 32'd1);
        chk("A_memr_low", 32'(nMemrLow), 32'd3);
        chk("A_iow_low", 32'(nIowLow), 32'd2);
        chk("A_HRQ_end", 32'(bus.HRQ), 32'd0);
        cyc(1);

        // Ch0 BLOCK WRITE, terminal count on the third word, clearStatus colliding with the set.
        clrCnt();
        bus.modeXfer[0] = BLOCK; bus.modeType[0] = WRITE; bus.grant = 4'b0001; bus.DREQ = 4'b0001;
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(4);
        bus.maskReg = 4'b0001;
        cyc(7);
        bus.countZero = 1'b1; bus.clearStatus = 1'b1;
        cyc(1);
        bus.clearStatus = 1'b0; bus.DREQ = 4'b0;
        chk("B_EOP_N_OUT_lastS4", 32'(bus.EOP_N_OUT), 32'd0);
        chk("B_tcStatus", 32'(bus.tcStatus), 32'h1);
        cyc(1);
        bus.countZero = 1'b0; bus.maskReg = 4'b0; bus.HLDA = 1'b0;
        cyc(1);
        chk("B_aen_cycles", 32'(nAen), 32'd12);
        chk("B_updates", 32'(nUpd), 32'd3);
        chk("B_eop_low", 32'(nEopLow), 32'd1);
        chk("B_ior_low", 32'(nIorLow), 32'd9);
        chk("B_memw_low", 32'(nMemwLow), 32'd6);

        bus.clearStatus = 1'b1;
        cyc(1);
        bus.clearStatus = 1'b0;
        chk("clear_tcStatus", 32'(bus.tcStatus), 32'd0);

        // Ch1 DEMAND VERIFY, request withdrawn during the second word.
        clrCnt();
        bus.modeXfer[1] = DEMAND; bus.modeType[1] = VERIFY; bus.grant = 4'b0010; bus.DREQ = 4'b0010;
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(6);
        bus.DREQ = 4'b0;
        cyc(3);
        bus.HLDA = 1'b0;
        cyc(1);
        chk("C_updates", 32'(nUpd), 32'd2);
        chk("C_aen_cycles", 32'(nAen), 32'd8);
        chk("C_tcStatus", 32'(bus.tcStatus), 32'd0);
        chk("C_no_strobes", 32'(nMemrLow + nIorLow + nIowLow + nMemwLow), 32'd0);

        // Ch3 BLOCK READ, one-cycle external EOP in S2 of the first word.
        clrCnt();
        bus.modeXfer[3] = BLOCK; bus.modeType[3] = READ; bus.grant = 4'b1000; bus.DREQ = 4'b1000;
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(2);
        bus.EOP_N_IN = 1'b0;
        cyc(1);
        bus.EOP_N_IN = 1'b1;
        cyc(1);
        bus.DREQ = 4'b0;
        cyc(1);
        bus.HLDA = 1'b0;
        cyc(1);
        chk("D_updates", 32'(nUpd), 32'd1);
        chk("D_aen_cycles", 32'(nAen), 32'd4);
        chk("D_no_eop_out", 32'(nEopLow), 32'd0);
        chk("D_tcStatus", 32'(bus.tcStatus), 32'd0);

        // HLDA lost in S2, then the request masked while holding in S0.
        clrCnt();
        bus.modeType[0] = READ; bus.grant = 4'b0001; bus.DREQ = 4'b0001;
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(2);
        bus.HLDA = 1'b0;
        cyc(1);
        chk("E_abort_MEMR_N", 32'(bus.MEMR_N), 32'd1);
        chk("E_abort_HRQ", 32'(bus.HRQ), 32'd0);
        chk("E_abort_DACK", 32'(bus.DACK), 32'd0);
        cyc(1);
        chk("E_rehold_HRQ", 32'(bus.HRQ), 32'd1);
        bus.maskReg = 4'b0001;
        cyc(1);
        chk("E_masked_HRQ", 32'(bus.HRQ), 32'd0);
        bus.maskReg = 4'b0; bus.DREQ = 4'b0;
        cyc(1);
        chk("E_assert_pulses", 32'(nAssert), 32'd1);
        chk("E_updates", 32'(nUpd), 32'd0);

        // Asynchronous reset in S3 while MEMR_N is low.
        bus.grant = 4'b0100; bus.DREQ = 4'b0100;
        cyc(1);
        bus.HLDA = 1'b1;
        cyc(3);
        chk("F_pre_MEMR_N", 32'(bus.MEMR_N), 32'd0);
        RESET_N = 1'b0;
        #1;
        chk("F_rst_MEMR_N", 32'(bus.MEMR_N), 32'd1);
        chk("F_rst_IOW_N", 32'(bus.IOW_N), 32'd1);
        chk("F_rst_HRQ", 32'(bus.HRQ), 32'd0);
        chk("F_rst_AEN", 32'(bus.AEN), 32'd0);
        chk("F_rst_DACK", 32'(bus.DACK), 32'd0);
        chk("F_rst_activeChannel", 32'(bus.activeChannel), 32'd0);
        chk("F_rst_update", 32'(bus.updateAddrCount), 32'd0);
        chk("F_rst_assertDACK", 32'(bus.assertDACK), 32'd0);
        bus.DREQ = 4'b0; bus.HLDA = 1'b0;
        cyc(1);
        RESET_N = 1'b1;
        cyc(2);
        chk("F_post_HRQ", 32'(bus.HRQ), 32'd0);

        // Disabled controller ignores requests.
        bus.ctrlEnable = 1'b0; bus.DREQ = 4'b1111;
        cyc(3);
        chk("G_disabled_HRQ", 32'(bus.HRQ), 32'd0);
        bus.ctrlEnable = 1'b1;
        cyc(1);
        chk("G_enabled_HRQ", 32'(bus.HRQ), 32'd1);
        bus.DREQ = 4'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
